// File: rtl/ap_pkg.sv
// Shared constants for the A*P result packer: default widths,
// FSM state encoding and an index-width helper.
package ap_pkg;

  localparam int def_element_width = 32;
  localparam int def_no_of_units   = 8;
  localparam int def_address_width = 32;
  localparam int def_equations     = 9;
  localparam int def_lane_width    = $clog2(def_no_of_units);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FILL  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ap_lane_buffer.sv
// Lane register file: U x element_width, per-lane load, sync clear.
// Ports: clk, rst_n, clear, load, lane, data -> words (packed lanes).
module ap_lane_buffer #(
  parameter int element_width = 32,
  parameter int no_of_units   = 8,
  parameter int lane_width    = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear,
  input  logic                                 load,
  input  logic [lane_width-1:0]                lane,
  input  logic [element_width-1:0]             data,
  output logic [element_width*no_of_units-1:0] words
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words <= '0;
    end else if (clear) begin
      words <= '0;
    end else if (load) begin
      words[lane*element_width +: element_width] <= data;
    end
  end

endmodule

// File: rtl/ap_result_packer.sv
// Packs A*P scalars into U-lane words and writes them to AP memory.
// Ports: start/base_address, in_* handshake, mem_* write port, busy, done.
module ap_result_packer
  import ap_pkg::*;
#(
  parameter int element_width                   = def_element_width,
  parameter int no_of_units                     = def_no_of_units,
  parameter int number_of_equations_per_cluster = def_equations,
  parameter int address_width                   = def_address_width
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [address_width-1:0]             base_address,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [element_width-1:0]             in_data,
  output logic                                 mem_write_enable,
  output logic [address_width-1:0]             mem_address,
  output logic [element_width*no_of_units-1:0] mem_data,
  output logic                                 busy,
  output logic                                 done
);

  localparam int lw = idx_width(no_of_units);
  localparam int cw = $clog2(number_of_equations_per_cluster + 1);
  localparam int dw = element_width * no_of_units;

  logic [1:0]               state;
  logic [lw-1:0]            lane;
  logic [cw-1:0]            count;
  logic [address_width-1:0] word_addr;
  logic [dw-1:0]            buf_q;
  logic [dw-1:0]            merged;
  logic                     accept;
  logic                     last;
  logic                     word_end;
  logic                     buf_clear;
  logic                     buf_load;

  assign in_ready = (state == FILL);
  assign accept   = in_valid & in_ready;
  assign last     = (count == cw'(number_of_equations_per_cluster - 1));
  assign word_end = accept & ((lane == lw'(no_of_units - 1)) | last);

  // A completing scalar bypasses the buffer straight into the word.
  assign buf_clear = ((state == IDLE) & start) | word_end;
  assign buf_load  = accept & ~word_end;

  ap_lane_buffer #(
    .element_width(element_width),
    .no_of_units  (no_of_units),
    .lane_width   (lw)
  ) u_buf (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(buf_clear),
    .load (buf_load),
    .lane (lane),
    .data (in_data),
    .words(buf_q)
  );

  // Unfilled lanes are already zero since the buffer is cleared per word.
  always_comb begin
    merged = buf_q;
    merged[lane*element_width +: element_width] = in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      lane             <= '0;
      count            <= '0;
      word_addr        <= '0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_data         <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      mem_write_enable <= 1'b0;
      done             <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            word_addr <= base_address;
            lane      <= '0;
            count     <= '0;
            busy      <= 1'b1;
            state     <= FILL;
          end
        end
        FILL: begin
          if (accept) begin
            count <= count + 1'b1;
            if (word_end) begin
              mem_write_enable <= 1'b1;
              mem_data         <= merged;
              mem_address      <= word_addr;
              word_addr        <= word_addr + 1'b1;
              lane             <= '0;
            end else begin
              lane <= lane + 1'b1;
            end
            if (last) begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
